axi_lite_subm_regs: RTL and testbench
=====================================

# axi_lite_subm_regs

AXI4-lite slave endpoint that terminates the `subm` submap port of the bus decoder, placed directly downstream of the decoder's `subm_*` master outputs. It implements two 32-bit registers selected by address bit 2:
- `CTRL` (offset 0x0) is read/write with byte strobes.
- `COUNT` (offset 0x4) is a read-only 32-bit event counter gated by `CTRL`.

Write and read channels are independent, so write and read traffic can overlap.

## Interface
Parameters:
- `CTRL_RESET`, default 32'h0000_0000: reset value of `CTRL`. Bit 1 is forced to 0 regardless of this value.

Ports:
- `aclk` in 1: clock; all logic rising-edge.
- `areset_n` in 1: reset areset_n, synchronous, active-low.
- `awvalid` in 1 / `awready` out 1 / `awaddr` in [2:2] / `awprot` in [2:0]: write address channel. `awprot` is ignored.
- `wvalid` in 1 / `wready` out 1 / `wdata` in 32 / `wstrb` in 4: write data channel.
- `bvalid` out 1 / `bready` in 1 / `bresp` out 2: write response channel.
- `arvalid` in 1 / `arready` out 1 / `araddr` in [2:2] / `arprot` in [2:0]: read address channel. `arprot` is ignored.
- `rvalid` out 1 / `rready` in 1 / `rdata` out 32 / `rresp` out 2: read data channel.
- `ctrl_o` out 32: current `CTRL` value, with bit 1 always 0.
- `count_o` out 32: current `COUNT` value.

## Operation
Reset (areset_n=0 at a rising edge): all outputs and internal state are cleared.
- `awready`, `wready`, `arready`, `bvalid`, `rvalid` = 0 during reset, then `awready`/`wready`/`arready` = 1 in the first cycle after release.
- `bresp`, `rresp`, `rdata`, `count_o` = 0.
- `ctrl_o` = `CTRL_RESET` with bit 1 cleared.
- Reset asserted mid-transaction discards any held AW/W halves and any pending response.

Write path:
- Flags `aw_held` and `w_held` latch `awaddr` and `wdata`/`wstrb` independently.
  - `awready = ~aw_held & ~bvalid`.
  - `wready = ~w_held & ~bvalid`.
- Commit occurs at the edge where both halves are available, either held or handshaking in that cycle. AW and W may arrive in either order or together.
- At commit, `bvalid` is set.
- When `bvalid & bready`: `bvalid`, `aw_held` and `w_held` are cleared.

Write effects:
- Write to `CTRL`: each byte lane `i` with `wstrb[i]=1` is updated.
  - Bit 0 = count enable.
  - Bit 1 = clear strobe. It is self-clearing, stored as 0, and zeroes `COUNT` at the commit edge when written 1 with `wstrb[0]=1`.
  - Bits 31:2 = general-purpose R/W.
- Write to `COUNT`: no register effect; `bresp` is set per Configuration.

Read path:
- `arready = ~rvalid`.
- An AR handshake at edge N captures the selected register into `rdata` at that same edge.
- `rvalid`=1 and `rresp`=2'b00 from the cycle after the handshake, held stable until `rvalid & rready`.

Counter:
- Each edge with `CTRL[0]=1`: `COUNT <= COUNT + 1`, modulo 2^32 (wraps 0xFFFF_FFFF -> 0).
- Clear strobe has priority over increment at the same edge.

## Timing
- Write: AW+W handshake together at edge N -> `bvalid`=1 and `ctrl_o` updated in cycle N+1. Minimum 2 cycles per write with `bready` held 1.
- AW at edge N, W at edge M>N -> commit at edge M.
- Read: AR handshake at edge N -> `rvalid` in cycle N+1. With `rready`=1 the next AR is accepted in cycle N+2.
- Simultaneous events:
  - A read and a commit at the same edge: the read returns the pre-commit value.
  - Enable written 1 at edge N: the first increment is at edge N+1.
  - `COUNT` read at edge N returns the value before that edge's increment.
- `bvalid`/`rvalid` held with `bready`/`rready`=0: outputs stay stable, and no further AW/W or AR is accepted.

## Configuration
- `AXI_LITE_SUBM_REGS_SLVERR_EN` defined: a write to `COUNT` returns `bresp`=2'b10 (SLVERR). Writes to `CTRL` and all reads return 2'b00.
- Undefined: `bresp` is always 2'b00, and writes to `COUNT` are silently dropped.

## Test plan
- Reset: hold areset_n=0 for 3 cycles, release -> `ctrl_o`=`CTRL_RESET`&~32'h2, `count_o`=0, `bvalid`=`rvalid`=0, ready outputs=1.
- Byte strobes: write `CTRL` 32'hA5A5_A5A0 with `wstrb`=4'b0101 over zero -> `ctrl_o`=32'h00A5_00A0, `bresp`=0, `bvalid` one cycle after the handshake.
- Split channels: W at cycle 2, AW at cycle 6 (`bready`=0 until cycle 10) -> single commit at cycle 6 edge, `wready` low from cycle 3, `bvalid` held cycles 7-10.
- Counter: write `CTRL`=1, wait 10 cycles, read `COUNT` -> 10 (±pipeline offset as specified). Write `CTRL`=3 -> `count_o`=0 next cycle, then resumes from 1.
- Wrap: enable, force count near 0xFFFF_FFFE via run, observe 0xFFFF_FFFF -> 0x0000_0000.
- Write to `COUNT` -> `bresp`=2'b10 with macro, 2'b00 without; `count_o` unchanged by the write in both.

Source files
------------

// File: rtl/axi_lite_subm_regs.sv
// axi_lite_subm_regs: AXI4-lite slave terminating the decoder's subm port.
// Two registers are selected by address bit 2:
//   0x0 CTRL  : R/W with byte strobes. Bit 0 is count enable. Bit 1 is a
//               self-clearing clear strobe. Bits 31:2 are general purpose.
//   0x4 COUNT : read-only event counter, incremented while CTRL[0] is set.
// The write and read channels run independently of each other.
// Optional build macro AXI_LITE_SUBM_REGS_SLVERR_EN: when it is defined, a
// write to COUNT answers SLVERR. Otherwise the write is dropped with OKAY.
module axi_lite_subm_regs #(
  parameter logic [31:0] CTRL_RESET = 32'h0000_0000
) (
  input  logic        aclk,
  input  logic        areset_n,
  // write address
  input  logic        awvalid,
  output logic        awready,
  input  logic [2:2]  awaddr,
  input  logic [2:0]  awprot,
  // write data
  input  logic        wvalid,
  output logic        wready,
  input  logic [31:0] wdata,
  input  logic [3:0]  wstrb,
  // write response
  output logic        bvalid,
  input  logic        bready,
  output logic [1:0]  bresp,
  // read address
  input  logic        arvalid,
  output logic        arready,
  input  logic [2:2]  araddr,
  input  logic [2:0]  arprot,
  // read data
  output logic        rvalid,
  input  logic        rready,
  output logic [31:0] rdata,
  output logic [1:0]  rresp,
  // register taps
  output logic [31:0] ctrl_o,
  output logic [31:0] count_o
);

  // The clear strobe is never stored, so bit 1 of the reset value is dropped.
  localparam logic [31:0] CTRL_RST = CTRL_RESET & ~32'h0000_0002;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
`ifdef AXI_LITE_SUBM_REGS_SLVERR_EN
  localparam logic [1:0] RESP_SLVERR = 2'b10;
`endif

  // Protection bits carry no meaning for this endpoint.
  logic unused_prot;
  assign unused_prot = ^{awprot, arprot};

  // ---------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------
  logic        rdy_en_q;                 // low in reset, opens all ready outputs
  logic        aw_held_q, aw_held_d;
  logic        awaddr_q,  awaddr_d;
  logic        w_held_q,  w_held_d;
  logic [31:0] wdata_q,   wdata_d;
  logic [3:0]  wstrb_q,   wstrb_d;
  logic        bvalid_q,  bvalid_d;
  logic [1:0]  bresp_q,   bresp_d;
  logic        rvalid_q,  rvalid_d;
  logic [31:0] rdata_q,   rdata_d;
  logic [31:0] ctrl_q,    ctrl_d;
  logic [31:0] count_q,   count_d;

  // ---------------------------------------------------------------------
  // Handshakes and the effective write request
  // ---------------------------------------------------------------------
  logic        aw_hs, w_hs, ar_hs, b_hs, r_hs;
  logic        wr_addr;
  logic [31:0] wr_data;
  logic [3:0]  wr_strb;
  logic        commit;
  logic        ctrl_wr;
  logic        cnt_clr;

  // A held half is blocked until its response is taken. A pending bvalid
  // also blocks new AW and W beats.
  assign awready = rdy_en_q & ~aw_held_q & ~bvalid_q;
  assign wready  = rdy_en_q & ~w_held_q  & ~bvalid_q;
  assign arready = rdy_en_q & ~rvalid_q;

  assign aw_hs = awvalid & awready;
  assign w_hs  = wvalid  & wready;
  assign ar_hs = arvalid & arready;
  assign b_hs  = bvalid_q & bready;
  assign r_hs  = rvalid_q & rready;

  // A half that is still in flight comes from the bus and not from the latch.
  // This lets AW and W commit at the same edge on which they handshake.
  assign wr_addr = aw_held_q ? awaddr_q : awaddr[2];
  assign wr_data = w_held_q  ? wdata_q  : wdata;
  assign wr_strb = w_held_q  ? wstrb_q  : wstrb;

  assign commit  = (aw_held_q | aw_hs) & (w_held_q | w_hs) & ~bvalid_q;
  assign ctrl_wr = commit & (wr_addr == 1'b0);
  assign cnt_clr = ctrl_wr & wr_strb[0] & wr_data[1];

  // Write-channel bookkeeping: latch each half, and release both on the B handshake.
  always_comb begin
    aw_held_d = aw_held_q;
    awaddr_d  = awaddr_q;
    w_held_d  = w_held_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    if (aw_hs) begin
      aw_held_d = 1'b1;
      awaddr_d  = awaddr[2];
    end
    if (w_hs) begin
      w_held_d = 1'b1;
      wdata_d  = wdata;
      wstrb_d  = wstrb;
    end
    if (b_hs) begin
      aw_held_d = 1'b0;
      w_held_d  = 1'b0;
    end
  end

  // Write response: raised at commit and held until the master takes it.
  always_comb begin
    bvalid_d = bvalid_q;
    bresp_d  = bresp_q;
    if (bvalid_q) begin
      bvalid_d = ~bready;
    end else if (commit) begin
      bvalid_d = 1'b1;
`ifdef AXI_LITE_SUBM_REGS_SLVERR_EN
      bresp_d  = wr_addr ? RESP_SLVERR : RESP_OKAY;
`else
      bresp_d  = RESP_OKAY;
`endif
    end
  end

  // CTRL byte-lane merge. Bit 1 always stores as 0.
  always_comb begin
    ctrl_d = ctrl_q;
    for (int i = 0; i < 4; i++) begin
      if (ctrl_wr && wr_strb[i]) ctrl_d[8*i +: 8] = wr_data[8*i +: 8];
    end
    ctrl_d[1] = 1'b0;
  end

  // Counter: a clear wins over the increment. It uses the enable from before this edge.
  always_comb begin
    count_d = count_q;
    if (cnt_clr)        count_d = 32'h0;
    else if (ctrl_q[0]) count_d = count_q + 32'h1;
  end

  // Read channel: capture the pre-edge register value on AR, then hold it until R is taken.
  always_comb begin
    rvalid_d = rvalid_q;
    rdata_d  = rdata_q;
    if (ar_hs) begin
      rvalid_d = 1'b1;
      rdata_d  = araddr[2] ? count_q : ctrl_q;
    end else if (r_hs) begin
      rvalid_d = 1'b0;
    end
  end

  // State register with synchronous active-low reset.
  always_ff @(posedge aclk) begin
    if (!areset_n) begin
      rdy_en_q  <= 1'b0;
      aw_held_q <= 1'b0;
      awaddr_q  <= 1'b0;
      w_held_q  <= 1'b0;
      wdata_q   <= 32'h0;
      wstrb_q   <= 4'h0;
      bvalid_q  <= 1'b0;
      bresp_q   <= RESP_OKAY;
      rvalid_q  <= 1'b0;
      rdata_q   <= 32'h0;
      ctrl_q    <= CTRL_RST;
      count_q   <= 32'h0;
    end else begin
      rdy_en_q  <= 1'b1;
      aw_held_q <= aw_held_d;
      awaddr_q  <= awaddr_d;
      w_held_q  <= w_held_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      bvalid_q  <= bvalid_d;
      bresp_q   <= bresp_d;
      rvalid_q  <= rvalid_d;
      rdata_q   <= rdata_d;
      ctrl_q    <= ctrl_d;
      count_q   <= count_d;
    end
  end

  assign bvalid  = bvalid_q;
  assign bresp   = bresp_q;
  assign rvalid  = rvalid_q;
  assign rdata   = rdata_q;
  assign rresp   = RESP_OKAY;
  assign ctrl_o  = ctrl_q;
  assign count_o = count_q;

endmodule

// File: tb/tb_axi_lite_subm_regs.sv
// Self-checking bench for axi_lite_subm_regs: table-driven CTRL writes plus
// hand sequences for split channels, back-pressure, counter, wrap and reset.
module tb_axi_lite_subm_regs;

  localparam logic [31:0] CTRL_RESET = 32'h1234_5676;
  localparam logic [31:0] CTRL_RST   = 32'h1234_5674;
`ifdef AXI_LITE_SUBM_REGS_SLVERR_EN
  localparam logic [1:0] COUNT_WR_RESP = 2'b10;
`else
  localparam logic [1:0] COUNT_WR_RESP = 2'b00;
`endif

  logic        aclk, areset_n;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rvalid, rready;
  logic [2:2]  awaddr, araddr;
  logic [2:0]  awprot, arprot;
  logic [31:0] wdata, rdata, ctrl_o, count_o;
  logic [3:0]  wstrb;
  logic [1:0]  bresp, rresp;

  axi_lite_subm_regs #(.CTRL_RESET(CTRL_RESET)) dut (
    .aclk(aclk), .areset_n(areset_n),
    .awvalid(awvalid), .awready(awready), .awaddr(awaddr), .awprot(awprot),
    .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb),
    .bvalid(bvalid), .bready(bready), .bresp(bresp),
    .arvalid(arvalid), .arready(arready), .araddr(araddr), .arprot(arprot),
    .rvalid(rvalid), .rready(rready), .rdata(rdata), .rresp(rresp),
    .ctrl_o(ctrl_o), .count_o(count_o)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  // cyc = number of rising edges seen so far; the next edge is cyc+1
  int cyc = 0;
  always @(posedge aclk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  // scoreboards
  logic [1:0]  eb[$];
  logic [31:0] er[$];

  // reference model
  logic [31:0] m_ctrl;
  logic        m_en;
  logic [31:0] m_base;       // COUNT value just after edge m_base_edge
  int          m_base_edge;

  function automatic logic [31:0] cnt_before(input int e);
    return m_base + (m_en ? 32'(e - 1 - m_base_edge) : 32'h0);
  endfunction

  function automatic void model_commit(input logic a, input logic [31:0] d,
                                       input logic [3:0] s, input int e);
    logic [31:0] nv;
    logic        clr;
    nv  = m_ctrl;
    clr = 1'b0;
    if (!a) begin
      for (int i = 0; i < 4; i++) if (s[i]) nv[8*i +: 8] = d[8*i +: 8];
      nv[1] = 1'b0;
      clr   = s[0] & d[1];
    end
    m_base      = clr ? 32'h0 : cnt_before(e) + (m_en ? 32'h1 : 32'h0);
    m_base_edge = e;
    m_en        = nv[0];
    m_ctrl      = nv;
    eb.push_back(a ? COUNT_WR_RESP : 2'b00);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic pop_b(input string nm);
    if (eb.size() == 0) chk({nm, " b-queue empty"}, 32'h1, 32'h0);
    else chk({nm, " bresp"}, 32'(bresp), 32'(eb.pop_front()));
  endtask

  task automatic pop_r(input string nm);
    if (er.size() == 0) chk({nm, " r-queue empty"}, 32'h1, 32'h0);
    else begin
      chk({nm, " rdata"}, rdata, er.pop_front());
      chk({nm, " rresp"}, 32'(rresp), 32'h0);
    end
  endtask

  task automatic do_reset(input int n);
    @(negedge aclk);
    areset_n = 1'b0;
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0; bready = 1'b0; rready = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(negedge aclk);
      chk("rst awready", 32'(awready), 32'h0);
      chk("rst wready",  32'(wready),  32'h0);
      chk("rst arready", 32'(arready), 32'h0);
      chk("rst bvalid",  32'(bvalid),  32'h0);
      chk("rst rvalid",  32'(rvalid),  32'h0);
    end
    areset_n    = 1'b1;
    m_ctrl      = CTRL_RST;
    m_en        = CTRL_RST[0];
    m_base      = 32'h0;
    m_base_edge = cyc;
    eb.delete();
    er.delete();
    @(negedge aclk);
    chk("post-rst ctrl_o",  ctrl_o,  CTRL_RST);
    chk("post-rst count_o", count_o, 32'h0);
    chk("post-rst rdata",   rdata,   32'h0);
    chk("post-rst bresp",   32'(bresp), 32'h0);
    chk("post-rst rresp",   32'(rresp), 32'h0);
    chk("post-rst bvalid",  32'(bvalid), 32'h0);
    chk("post-rst rvalid",  32'(rvalid), 32'h0);
    chk("post-rst awready", 32'(awready), 32'h1);
    chk("post-rst wready",  32'(wready),  32'h1);
    chk("post-rst arready", 32'(arready), 32'h1);
  endtask

  // AW and W presented together with bready held high
  task automatic axi_write(input logic a, input logic [31:0] d, input logic [3:0] s);
    int n;
    @(negedge aclk);
    awvalid = 1'b1; awaddr = a; wvalid = 1'b1; wdata = d; wstrb = s; bready = 1'b1;
    n = 0;
    while (!(awready === 1'b1 && wready === 1'b1) && n < 50) begin
      @(negedge aclk);
      n++;
    end
    if (n >= 50) begin
      chk("write timeout", 32'h1, 32'h0);
      awvalid = 1'b0; wvalid = 1'b0;
      return;
    end
    model_commit(a, d, s, cyc + 1);
    @(negedge aclk);
    awvalid = 1'b0; wvalid = 1'b0;
    chk("wr bvalid", 32'(bvalid), 32'h1);
    if (bvalid === 1'b1) pop_b("wr");
    chk("wr ctrl_o",  ctrl_o,  m_ctrl);
    chk("wr count_o", count_o, cnt_before(cyc + 1));
    @(negedge aclk);
    chk("wr bvalid drop", 32'(bvalid), 32'h0);
  endtask

  task automatic axi_read(input logic a);
    int n;
    @(negedge aclk);
    arvalid = 1'b1; araddr = a; rready = 1'b1;
    n = 0;
    while (arready !== 1'b1 && n < 50) begin
      @(negedge aclk);
      n++;
    end
    if (n >= 50) begin
      chk("read timeout", 32'h1, 32'h0);
      arvalid = 1'b0;
      return;
    end
    er.push_back(a ? cnt_before(cyc + 1) : m_ctrl);
    @(negedge aclk);
    arvalid = 1'b0;
    chk("rd rvalid", 32'(rvalid), 32'h1);
    if (rvalid === 1'b1) pop_r("rd");
    @(negedge aclk);
    chk("rd next arready", 32'(arready), 32'h1);
  endtask

  typedef struct {
    logic        addr;
    logic [31:0] data;
    logic [3:0]  strb;
    logic [31:0] exp_ctrl;
  } vec_t;

  vec_t vecs[7];

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin : main
    logic [31:0] hold_v;
    vecs[0] = '{1'b0, 32'h0000_0000, 4'b1111, 32'h0000_0000};
    vecs[1] = '{1'b0, 32'hA5A5_A5A0, 4'b0101, 32'h00A5_00A0};
    vecs[2] = '{1'b0, 32'hFFFF_FFFC, 4'b1010, 32'hFFA5_FFA0};
    vecs[3] = '{1'b0, 32'h1234_5678, 4'b0001, 32'hFFA5_FF78};
    vecs[4] = '{1'b0, 32'h0000_00FE, 4'b0001, 32'hFFA5_FFFC};
    vecs[5] = '{1'b1, 32'hDEAD_BEEF, 4'b1111, 32'hFFA5_FFFC};
    vecs[6] = '{1'b0, 32'h0000_0000, 4'b1111, 32'h0000_0000};

    areset_n = 1'b0;
    awvalid = 1'b0; awaddr = 1'b0; awprot = 3'b000;
    wvalid = 1'b0; wdata = 32'h0; wstrb = 4'h0; bready = 1'b0;
    arvalid = 1'b0; araddr = 1'b0; arprot = 3'b000; rready = 1'b0;

    do_reset(3);
    axi_read(1'b0);

    // table of CTRL/COUNT writes with readback
    for (int i = 0; i < 7; i++) begin
      axi_write(vecs[i].addr, vecs[i].data, vecs[i].strb);
      chk($sformatf("vec%0d ctrl_o", i), ctrl_o, vecs[i].exp_ctrl);
      axi_read(1'b0);
    end

    // split channels: W first, AW four cycles later, B back-pressured
    @(negedge aclk);
    wvalid = 1'b1; wdata = 32'h0000_5A00; wstrb = 4'b0010; bready = 1'b0;
    @(negedge aclk);
    wvalid = 1'b0;
    chk("split wready low", 32'(wready), 32'h0);
    for (int i = 0; i < 3; i++) begin
      @(negedge aclk);
      chk("split no early b", 32'(bvalid), 32'h0);
      chk("split ctrl held", ctrl_o, m_ctrl);
    end
    awvalid = 1'b1; awaddr = 1'b0;
    model_commit(1'b0, 32'h0000_5A00, 4'b0010, cyc + 1);
    @(negedge aclk);
    awvalid = 1'b0;
    chk("split ctrl_o", ctrl_o, 32'h0000_5A00);
    for (int i = 0; i < 4; i++) begin
      chk("split bvalid held", 32'(bvalid), 32'h1);
      chk("split bresp held",  32'(bresp),  32'h0);
      chk("split awready low", 32'(awready), 32'h0);
      if (i < 3) @(negedge aclk);
    end
    bready = 1'b1;
    pop_b("split");
    @(negedge aclk);
    chk("split bvalid drop", 32'(bvalid), 32'h0);
    chk("split awready", 32'(awready), 32'h1);
    chk("split wready",  32'(wready),  32'h1);

    // read and commit at the same edge: read sees the old CTRL
    @(negedge aclk);
    awvalid = 1'b1; awaddr = 1'b0; wvalid = 1'b1; wdata = 32'h0; wstrb = 4'b1111;
    arvalid = 1'b1; araddr = 1'b0; bready = 1'b1; rready = 1'b1;
    er.push_back(m_ctrl);
    model_commit(1'b0, 32'h0, 4'b1111, cyc + 1);
    @(negedge aclk);
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
    chk("same-edge bvalid", 32'(bvalid), 32'h1);
    chk("same-edge rvalid", 32'(rvalid), 32'h1);
    pop_b("same-edge");
    pop_r("same-edge");
    chk("same-edge ctrl_o", ctrl_o, 32'h0);
    @(negedge aclk);

    // R back-pressure: rdata stable, no second AR accepted
    @(negedge aclk);
    arvalid = 1'b1; araddr = 1'b0; rready = 1'b0;
    er.push_back(m_ctrl);
    @(negedge aclk);
    hold_v = rdata;
    for (int i = 0; i < 3; i++) begin
      chk("rhold rvalid",  32'(rvalid),  32'h1);
      chk("rhold arready", 32'(arready), 32'h0);
      chk("rhold rdata",   rdata, hold_v);
      @(negedge aclk);
    end
    pop_r("rhold");
    arvalid = 1'b0; rready = 1'b1;
    @(negedge aclk);
    chk("rhold rvalid drop", 32'(rvalid), 32'h0);

    // counter: enable, run, read, then clear+enable
    axi_write(1'b0, 32'h0000_0001, 4'b0001);
    repeat (10) @(negedge aclk);
    chk("run count_o", count_o, cnt_before(cyc + 1));
    axi_read(1'b1);
    axi_write(1'b0, 32'h0000_0003, 4'b0001);
    chk("clr ctrl bit1", ctrl_o, 32'h0000_0001);
    chk("clr resume", count_o, 32'h0000_0001);
    axi_write(1'b1, 32'h0000_DEAD, 4'b1111);
    chk("cnt-wr count_o", count_o, cnt_before(cyc + 1));
    axi_read(1'b1);

    // wrap: preload near the top while counting
    @(negedge aclk);
    force dut.count_q = 32'hFFFF_FFFD;
    #1 release dut.count_q;
    m_base = 32'hFFFF_FFFD;
    m_base_edge = cyc;
    begin
      logic [31:0] wrap_seq [4];
      wrap_seq[0] = 32'hFFFF_FFFE;
      wrap_seq[1] = 32'hFFFF_FFFF;
      wrap_seq[2] = 32'h0000_0000;
      wrap_seq[3] = 32'h0000_0001;
      for (int i = 0; i < 4; i++) begin
        @(negedge aclk);
        chk($sformatf("wrap step%0d", i), count_o, wrap_seq[i]);
      end
    end

    // reset mid-transaction discards a held W half
    @(negedge aclk);
    wvalid = 1'b1; wdata = 32'hFFFF_FFFF; wstrb = 4'b1111; bready = 1'b1;
    @(negedge aclk);
    wvalid = 1'b0;
    chk("mid wready low", 32'(wready), 32'h0);
    do_reset(2);
    @(negedge aclk);
    awvalid = 1'b1; awaddr = 1'b0; bready = 1'b1;
    @(negedge aclk);
    awvalid = 1'b0;
    chk("mid aw only no b", 32'(bvalid), 32'h0);
    chk("mid aw held",      32'(awready), 32'h0);
    chk("mid w open",       32'(wready),  32'h1);
    wvalid = 1'b1; wdata = 32'hCAFE_0000; wstrb = 4'b1100;
    model_commit(1'b0, 32'hCAFE_0000, 4'b1100, cyc + 1);
    @(negedge aclk);
    wvalid = 1'b0;
    chk("mid bvalid", 32'(bvalid), 32'h1);
    pop_b("mid");
    chk("mid ctrl_o", ctrl_o, 32'hCAFE_5674);
    @(negedge aclk);
    chk("mid bvalid drop", 32'(bvalid), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
